// File: rtl/cix_seq.sv
// Sequential clz / ctz / popcount / zero-count over a 2**ORDER-bit word, one 2**CORDER-bit chunk
// per clock. Optional early exit for clz/ctz: define CIX_SEQ_EARLY_EXIT_EN.
module cix_seq #(
    parameter int unsigned ORDER  = 5,
    parameter int unsigned CORDER = 3
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [1:0]          mode,
    input  logic [2**ORDER-1:0] in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ORDER:0]      count,
    output logic                zero
);

    localparam int unsigned W  = 2**ORDER;
    localparam int unsigned C  = 2**CORDER;
    localparam int unsigned N  = 2**(ORDER-CORDER);
    localparam int unsigned IW = (ORDER > CORDER) ? ORDER - CORDER : 1;

    typedef logic [ORDER:0] cnt_t;

    typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

    function automatic cnt_t lead_zeros(input logic [C-1:0] v);
        cnt_t r;
        r = cnt_t'(C);
        for (int i = 0; i < C; i++) begin
            if (v[i]) r = cnt_t'(C - 1 - i);
        end
        return r;
    endfunction

    function automatic cnt_t trail_zeros(input logic [C-1:0] v);
        cnt_t r;
        r = cnt_t'(C);
        for (int i = C - 1; i >= 0; i--) begin
            if (v[i]) r = cnt_t'(i);
        end
        return r;
    endfunction

    function automatic cnt_t pop_count(input logic [C-1:0] v);
        cnt_t r;
        r = '0;
        for (int i = 0; i < C; i++) begin
            r = r + cnt_t'(v[i]);
        end
        return r;
    endfunction

    state_e         state_q, state_d;
    logic [W-1:0]   shreg_q, shreg_d;
    cnt_t           acc_q, acc_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [1:0]     op_q, op_d;
    logic           trk_q, trk_d;
    logic           seen_q, seen_d;
    cnt_t           count_q, count_d;
    logic           zero_q, zero_d;
    logic           valid_q, valid_d;

    logic [C-1:0]   chunk_hi, chunk_lo;
    cnt_t           add, acc_sum;
    logic [W-1:0]   shifted;
    logic           nz, last, finish;

    assign chunk_hi = shreg_q[W-1 -: C];
    assign chunk_lo = shreg_q[C-1:0];
    assign last     = (idx_q == IW'(N - 1));

    always_comb begin
        add     = '0;
        nz      = 1'b0;
        shifted = shreg_q >> C;
        unique case (op_q)
            2'b00: begin
                nz      = |chunk_hi;
                shifted = shreg_q << C;
                // Once a one has been seen, later chunks contribute nothing.
                add     = seen_q ? '0 : lead_zeros(chunk_hi);
            end
            2'b01: begin
                nz  = |chunk_lo;
                add = seen_q ? '0 : trail_zeros(chunk_lo);
            end
            default: begin
                nz  = |chunk_lo;
                add = pop_count(chunk_lo);
            end
        endcase
    end

    assign acc_sum = acc_q + add;

`ifdef CIX_SEQ_EARLY_EXIT_EN
    assign finish = last | (~op_q[1] & nz);
`else
    assign finish = last;
`endif

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        op_d    = op_q;
        trk_d   = trk_q;
        seen_d  = seen_q;
        count_d = count_q;
        zero_d  = zero_q;
        valid_d = valid_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    shreg_d = in;
                    op_d    = mode;
                    acc_d   = '0;
                    idx_d   = '0;
                    trk_d   = 1'b1;
                    seen_d  = 1'b0;
                    state_d = StScan;
                end
            end
            StScan: begin
                shreg_d = shifted;
                acc_d   = acc_sum;
                idx_d   = idx_q + IW'(1);
                trk_d   = trk_q & ~nz;
                seen_d  = seen_q | nz;
                if (finish) begin
                    state_d = StDone;
                    valid_d = 1'b1;
                    count_d = (op_q == 2'b11) ? cnt_t'(W) - acc_sum : acc_sum;
                    zero_d  = trk_q & ~nz;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                    valid_d = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            shreg_q <= '0;
            acc_q   <= '0;
            idx_q   <= '0;
            op_q    <= '0;
            trk_q   <= 1'b0;
            seen_q  <= 1'b0;
            count_q <= '0;
            zero_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            op_q    <= op_d;
            trk_q   <= trk_d;
            seen_q  <= seen_d;
            count_q <= count_d;
            zero_q  <= zero_d;
            valid_q <= valid_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = valid_q;
    assign count     = count_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_cix_seq.sv
// Scoreboard bench for cix_seq (W=32, N=4): driver pushes expected results, a negedge monitor
// pops and compares on each output handshake. Latency expectations follow CIX_SEQ_EARLY_EXIT_EN.
module tb_cix_seq;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  mode;
    logic [31:0] din;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  count;
    logic        zero;

    int checks = 0;
    int errors = 0;
    logic [6:0] exp_q[$];
    logic [6:0] mon_e;

    cix_seq #(.ORDER(5), .CORDER(3)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .in        (din),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count),
        .zero      (zero)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    function automatic int lat(input int early, input int full);
`ifdef CIX_SEQ_EARLY_EXIT_EN
        return early;
`else
        return full;
`endif
    endfunction

    always @(negedge clock) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got count %0d, required no result", count);
            end else begin
                mon_e = exp_q.pop_front();
                check("result_count", {26'd0, count}, {26'd0, mon_e[6:1]});
                check("result_zero", {31'd0, zero}, {31'd0, mon_e[0]});
            end
        end
    end

    task automatic wait_valid(input string name, input int elat);
        int n;
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clock); #1;
            n++;
        end
        check(name, n, elat);
    endtask

    task automatic wait_handshake();
        int n;
        n = 0;
        while (out_valid && n < 50) begin
            @(posedge clock); #1;
            n++;
        end
        check("handshake_done", {31'd0, out_valid}, 32'd0);
    endtask

    // Entered and left at posedge+1.
    task automatic run_op(input logic [31:0] word, input logic [1:0] md, input int ecnt,
                          input logic ezero, input int elat, input string name);
        int n;
        exp_q.push_back({ecnt[5:0], ezero});
        din      = word;
        mode     = md;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clock); #1;
            n++;
        end
        check({name, "_ready"}, {31'd0, in_ready}, 32'd1);
        @(posedge clock); #1;
        in_valid = 1'b0;
        din      = $urandom;
        mode     = ~md;
        wait_valid({name, "_latency"}, elat);
        wait_handshake();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        int seen;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        mode      = 2'b00;
        din       = '0;
        #3;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_count", {26'd0, count}, 32'd0);
        check("rst_zero", {31'd0, zero}, 32'd0);
        @(posedge clock);
        @(posedge clock); #1;
        reset = 1'b0;

        run_op(32'h0001_0000, 2'b00, 15, 1'b0, lat(2, 4), "clz_a");
        run_op(32'h8000_0000, 2'b01, 31, 1'b0, 4, "ctz_a");
        run_op(32'h0000_0100, 2'b01, 8, 1'b0, lat(2, 4), "ctz_b");
        run_op(32'hFFFF_0001, 2'b10, 17, 1'b0, 4, "pop_a");
        run_op(32'hFFFF_0001, 2'b11, 15, 1'b0, 4, "zc_a");
        run_op(32'h0000_0000, 2'b00, 32, 1'b1, 4, "clz_zero");
        run_op(32'h0000_0000, 2'b01, 32, 1'b1, 4, "ctz_zero");
        run_op(32'h0000_0000, 2'b10, 0, 1'b1, 4, "pop_zero");
        run_op(32'h0000_0000, 2'b11, 32, 1'b1, 4, "zc_zero");

        // Reset during a popcount scan; previous result (32, zero=1) must vanish at once.
        din      = 32'hFFFF_0001;
        mode     = 2'b10;
        in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        @(posedge clock); #1;
        #2;
        reset = 1'b1;
        #1;
        check("abort_out_valid", {31'd0, out_valid}, 32'd0);
        check("abort_count", {26'd0, count}, 32'd0);
        check("abort_zero", {31'd0, zero}, 32'd0);
        check("abort_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clock);
        @(posedge clock); #1;
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clock); #1;
            if (out_valid) seen++;
        end
        check("abort_no_result", seen, 0);
        run_op(32'h0000_0001, 2'b00, 31, 1'b0, 4, "clz_after_rst");

        // Backpressure with a second request waiting.
        out_ready = 1'b0;
        exp_q.push_back({6'd15, 1'b0});
        din      = 32'h0001_0000;
        mode     = 2'b00;
        in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        wait_valid("bp_first_latency", lat(2, 4));
        exp_q.push_back({6'd17, 1'b0});
        din      = 32'hFFFF_0001;
        mode     = 2'b10;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clock); #1;
            check("bp_out_valid", {31'd0, out_valid}, 32'd1);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check("bp_count", {26'd0, count}, 32'd15);
            check("bp_zero", {31'd0, zero}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clock); #1;
        check("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
        check("bp_release_out_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clock); #1;
        check("bp_second_accept", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b0;
        wait_valid("bp_second_latency", 4);
        wait_handshake();

        repeat (3) @(posedge clock);
        #1;
        check("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cix_seq.md
# cix_seq

Sequential multi-mode bit counter. It scans a 2**ORDER-bit word in 2**CORDER-bit chunks, one chunk per clock. It computes clz, ctz, popcount or zero-count under a valid/ready handshake on both sides. It is the area-reduced, wide-word successor to the combinational cix/clz/ctz/popcount family, for datapaths where several cycles of latency are acceptable.

## Interface
- ORDER, 5, word width W = 2**ORDER
- CORDER, 3, chunk width C = 2**CORDER; legal range 0 <= CORDER <= ORDER; chunk count N = 2**(ORDER-CORDER)
- clock  in  1  single clock; all state updates on its rising edge
- reset  in  1  asynchronous, active-high; forces IDLE immediately
- in_valid  in  1  request strobe
- in_ready  out  1  high only in IDLE
- mode  in  2  00 clz, 01 ctz, 10 popcount, 11 zero-count (W − popcount)
- in  in  W  word to scan, sampled with mode at accept
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- count  out  ORDER+1  result, range 0..W
- zero  out  1  sampled word was all zeros

## Operation
- States: IDLE, SCAN, DONE.
  - Reset value: IDLE, shift register 0, accumulator 0, chunk index 0, count 0, zero 0, out_valid 0.
  - in_ready is 1 while reset is held.
- **IDLE**
  - in_ready = 1, out_valid = 0.
  - When in_valid & in_ready: latch in, mode; clear accumulator and index; set the all-zero tracker; go to SCAN.
- **SCAN**, one chunk per cycle.
  - clz: top C bits; accumulator += leading zeros of chunk (0..C); shift left by C.
  - ctz: bottom C bits; accumulator += trailing zeros of chunk; shift right by C.
  - popcount / zero-count: accumulator += popcount of bottom chunk; shift right by C.
  - clz/ctz stop adding once a nonzero chunk has been seen.
  - The all-zero tracker clears on any nonzero chunk.
  - Leave SCAN to DONE after chunk N−1. With early exit (see Configuration), clz/ctz also leave on the first nonzero chunk.
- **DONE**
  - out_valid = 1.
  - count = accumulator, or W − accumulator for mode 11.
  - zero = tracker.
  - count and zero hold stable until out_valid & out_ready, then go to IDLE.
- Arithmetic and widths:
  - The accumulator is ORDER+1 bits and never exceeds W, so there is no wrap.
  - An all-zero input gives clz = ctz = W, popcount = 0, zero-count = W, zero = 1.
- in_valid is ignored outside IDLE. No request is queued and none is lost; the producer holds its request.
- Changes to in/mode after accept have no effect.
- Reset asserted in any state aborts the operation. Outputs return to reset values asynchronously and no result is emitted.

## Timing
- Accept occurs on edge E0.
- out_valid rises after edge Ek, where k is the number of chunks processed:
  - k = N for popcount and zero-count, and for all modes without early exit.
  - With early exit, clz/ctz use k = index of first nonzero chunk + 1, with a minimum of 1.
- Handshake completes on the edge where out_valid & out_ready.
  - in_ready is 1 in the following cycle.
  - A new accept occurs no earlier than the next edge.
- Minimum initiation interval: k + 2 cycles.
- out_valid, count and zero are registered. in_ready decodes the state only.

## Configuration
- CIX_SEQ_EARLY_EXIT_EN
  - Defined: clz/ctz finish on the first nonzero chunk, giving variable latency.
  - Undefined: every mode always scans N chunks, giving fixed latency N.
  - Results are identical either way; only latency differs.

## Test plan
All scenarios use ORDER=5, CORDER=3 (W=32, N=4).

1. **clz** of 0x00010000 → count 15, zero 0. out_valid after 2 scan cycles with CIX_SEQ_EARLY_EXIT_EN, after 4 without.
2. **ctz** of 0x80000000 → count 31, zero 0, 4 scan cycles in both builds. ctz of 0x00000100 → 8, 2 cycles with early exit.
3. **popcount** of 0xFFFF0001 → 17. Mode 11 on the same word → 15. Both take exactly 4 scan cycles.
4. **All-zero input** 0x00000000 in each mode → clz 32, ctz 32, pop 0, zero-count 32; zero = 1 in all cases.
5. **Backpressure**:
   - Hold out_ready low for 5 cycles with in_valid high and a new word presented.
   - Required: count/zero stable, in_ready = 0, no second accept.
   - Raise out_ready: handshake completes, in_ready = 1 next cycle, second word accepted and its result correct.
6. **Reset mid-operation**:
   - Assert reset asynchronously during SCAN of a popcount.
   - Required: out_valid, count and zero drop to 0 without waiting for a clock edge, no result emitted, in_ready = 1.
   - A subsequent clz of 0x00000001 → 31.
